// File: rtl/if_control_flow_tracker.sv
`default_nettype none
// ============================================================================
// Module   : if_control_flow_tracker
// Brief    : Fetch redirect arbiter (trap > mret > branch > pred) with flush
//            window, registered holdoffs and registered stall history.
//            Prediction path enabled by `FROST_BRANCH_PREDICTION_EN.
// Revision : 1.0 - initial release
// ============================================================================
module if_control_flow_tracker #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_stall,
    input  logic            i_trap_taken,
    input  logic [XLEN-1:0] i_trap_target,
    input  logic            i_mret_taken,
    input  logic [XLEN-1:0] i_mret_target,
    input  logic            i_branch_taken,
    input  logic [XLEN-1:0] i_branch_target,
    input  logic            i_pred_taken,
    input  logic [XLEN-1:0] i_pred_target,
    input  logic            i_halfword_holdoff_registered,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic [1:0]      o_redirect_cause,
    output logic            o_flush,
    output logic            o_control_flow_holdoff,
    output logic            o_prediction_holdoff,
    output logic            o_any_holdoff_safe,
    output logic            o_stall_registered
);

    localparam logic [1:0] c_cause_none   = 2'd0;
    localparam logic [1:0] c_cause_pred   = 2'd1;
    localparam logic [1:0] c_cause_branch = 2'd2;
    localparam logic [1:0] c_cause_trap   = 2'd3;

    logic [1:0] r_flush_cnt;
    logic       r_control_flow_holdoff;
    logic       r_stall_registered;
    logic       w_trap_accept;
    logic       w_mret_accept;
    logic       w_branch_accept;
    logic       w_cf_accept;
    logic       w_pred_accept;
    logic       w_flush_active;

    assign w_trap_accept   = i_trap_taken;
    assign w_mret_accept   = !i_trap_taken && i_mret_taken;
    assign w_branch_accept = !i_trap_taken && !i_mret_taken && i_branch_taken && !i_stall;
    assign w_cf_accept     = w_trap_accept || w_mret_accept || w_branch_accept;
    assign w_flush_active  = (r_flush_cnt != 2'd0);

`ifdef FROST_BRANCH_PREDICTION_EN
    logic r_prediction_holdoff;

    // Predictions from instructions still inside a flush or holdoff window are stale.
    assign w_pred_accept = i_pred_taken && !i_stall && !w_flush_active && !o_any_holdoff_safe
                           && !(i_trap_taken || i_mret_taken || i_branch_taken);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prediction_holdoff <= 1'b0;
        end else begin
            r_prediction_holdoff <= w_pred_accept;
        end
    end

    assign o_prediction_holdoff = r_prediction_holdoff;
`else
    logic w_unused_pred;

    assign w_unused_pred        = ^{i_pred_taken, i_pred_target};
    assign w_pred_accept        = 1'b0;
    assign o_prediction_holdoff = 1'b0;
`endif

    always_comb begin
        o_redirect_valid = 1'b0;
        o_redirect_pc    = '0;
        o_redirect_cause = c_cause_none;
        if (w_trap_accept) begin
            o_redirect_valid = 1'b1;
            o_redirect_pc    = i_trap_target;
            o_redirect_cause = c_cause_trap;
        end else if (w_mret_accept) begin
            o_redirect_valid = 1'b1;
            o_redirect_pc    = i_mret_target;
            o_redirect_cause = c_cause_trap;
        end else if (w_branch_accept) begin
            o_redirect_valid = 1'b1;
            o_redirect_pc    = i_branch_target;
            o_redirect_cause = c_cause_branch;
        end else if (w_pred_accept) begin
            o_redirect_valid = 1'b1;
`ifdef FROST_BRANCH_PREDICTION_EN
            o_redirect_pc    = i_pred_target;
`endif
            o_redirect_cause = c_cause_pred;
        end
    end

    // Counter holds while stalled because the fetch BRAM output is held too.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_flush_cnt            <= 2'd0;
            r_control_flow_holdoff <= 1'b0;
            r_stall_registered     <= 1'b0;
        end else begin
            if (w_cf_accept) begin
                r_flush_cnt <= 2'd1;
            end else if (!i_stall && w_flush_active) begin
                r_flush_cnt <= r_flush_cnt - 2'd1;
            end
            r_control_flow_holdoff <= w_cf_accept;
            r_stall_registered     <= i_stall;
        end
    end

    assign o_flush                = w_cf_accept || w_flush_active;
    assign o_control_flow_holdoff = r_control_flow_holdoff;
    assign o_any_holdoff_safe     = r_control_flow_holdoff || o_prediction_holdoff
                                    || i_halfword_holdoff_registered;
    assign o_stall_registered     = r_stall_registered;

endmodule
`default_nettype wire

// File: tb/tb_if_control_flow_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_control_flow_tracker
// Brief    : Table-driven bench with expected-value queue for the redirect
//            tracker; prediction expectations follow `FROST_BRANCH_PREDICTION_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_control_flow_tracker;

`ifdef FROST_BRANCH_PREDICTION_EN
    localparam bit c_pe = 1'b1;
`else
    localparam bit c_pe = 1'b0;
`endif
    localparam logic [31:0] c_trap_t = 32'h0000_0080;
    localparam logic [31:0] c_mret_t = 32'h0000_0500;
    localparam logic [31:0] c_pred_t = 32'h0000_0040;

    typedef struct {
        string       name;
        bit          chk;
        logic        rst, stall, trap, mret, br, pred, hw;
        logic [31:0] br_t;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [1:0]  e_cause;
        logic        e_flush, e_cfh, e_ph, e_any, e_sr;
    } vec_t;

    typedef struct {
        string       name;
        logic [39:0] exp;
    } sb_t;

    logic        i_clk = 1'b0;
    logic        i_reset, i_stall, i_trap_taken, i_mret_taken, i_branch_taken, i_pred_taken;
    logic        i_halfword_holdoff_registered;
    logic [31:0] i_trap_target, i_mret_target, i_branch_target, i_pred_target;
    logic        o_redirect_valid, o_flush, o_control_flow_holdoff, o_prediction_holdoff;
    logic        o_any_holdoff_safe, o_stall_registered;
    logic [31:0] o_redirect_pc;
    logic [1:0]  o_redirect_cause;

    int   n_applied = 0;
    int   n_miscompares = 0;
    vec_t table_q[$];
    sb_t  sb_q[$];

    if_control_flow_tracker #(.XLEN(32)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall),
        .i_trap_taken(i_trap_taken), .i_trap_target(i_trap_target),
        .i_mret_taken(i_mret_taken), .i_mret_target(i_mret_target),
        .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
        .i_pred_taken(i_pred_taken), .i_pred_target(i_pred_target),
        .i_halfword_holdoff_registered(i_halfword_holdoff_registered),
        .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
        .o_redirect_cause(o_redirect_cause), .o_flush(o_flush),
        .o_control_flow_holdoff(o_control_flow_holdoff),
        .o_prediction_holdoff(o_prediction_holdoff),
        .o_any_holdoff_safe(o_any_holdoff_safe), .o_stall_registered(o_stall_registered)
    );

    always #5 i_clk = ~i_clk;

    function automatic vec_t mkv(string name, bit chk, logic rst, logic stall, logic trap,
                                 logic mret, logic br, logic pred, logic hw, logic [31:0] br_t,
                                 logic valid, logic [31:0] pc, logic [1:0] cause, logic flush,
                                 logic cfh, logic ph, logic any, logic sr);
        vec_t v;
        v.name = name; v.chk = chk; v.rst = rst; v.stall = stall; v.trap = trap;
        v.mret = mret; v.br = br; v.pred = pred; v.hw = hw; v.br_t = br_t;
        v.e_valid = valid; v.e_pc = pc; v.e_cause = cause; v.e_flush = flush;
        v.e_cfh = cfh; v.e_ph = ph; v.e_any = any; v.e_sr = sr;
        return v;
    endfunction

    // Drive just after the edge, push the expectation, compare mid-cycle.
    task automatic apply(input vec_t v);
        sb_t         s;
        logic [39:0] act;
        @(posedge i_clk);
        #1;
        i_reset = v.rst; i_stall = v.stall; i_trap_taken = v.trap; i_mret_taken = v.mret;
        i_branch_taken = v.br; i_pred_taken = v.pred; i_halfword_holdoff_registered = v.hw;
        i_branch_target = v.br_t;
        if (v.chk) begin
            s.name = v.name;
            s.exp  = {v.e_valid, v.e_pc, v.e_cause, v.e_flush, v.e_cfh, v.e_ph, v.e_any, v.e_sr};
            sb_q.push_back(s);
        end
        @(negedge i_clk);
        if (sb_q.size() > 0) begin
            s   = sb_q.pop_front();
            act = {o_redirect_valid, o_redirect_pc, o_redirect_cause, o_flush,
                   o_control_flow_holdoff, o_prediction_holdoff, o_any_holdoff_safe,
                   o_stall_registered};
            n_applied++;
            if (act !== s.exp) begin
                n_miscompares++;
                $display("FAIL %s: got {valid,pc,cause,flush,cfh,ph,any,sr}=%h, want %h",
                         s.name, act, s.exp);
            end
        end
    endtask

    initial begin
        int k;
        i_reset = 1'b1; i_stall = 1'b0; i_trap_taken = 1'b0; i_mret_taken = 1'b0;
        i_branch_taken = 1'b0; i_pred_taken = 1'b0; i_halfword_holdoff_registered = 1'b0;
        i_trap_target = c_trap_t; i_mret_target = c_mret_t; i_pred_target = c_pred_t;
        i_branch_target = 32'h0;

        //                 name              chk rst stl trp mrt br  prd hw  br_t    | vld pc  cause flush cfh ph any sr
        for (int i = 0; i < 3; i++)
            table_q.push_back(mkv("reset_hold", 0, 1, 0, 1, 1, 1, 1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0));
        table_q.push_back(mkv("rst_release",      1, 0, 0, 1, 1, 1, 1, 0, 32'h100, 1, c_trap_t, 3, 1, 0, 0, 0, 0));
        table_q.push_back(mkv("trap_n1",          1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 1, 1, 0, 1, 0));
        table_q.push_back(mkv("trap_n2",          1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0));
        table_q.push_back(mkv("branch_n",         1, 0, 0, 0, 0, 1, 0, 0, 32'h100, 1, 32'h100, 2, 1, 0, 0, 0, 0));
        table_q.push_back(mkv("branch_n1",        1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 1, 1, 0, 1, 0));
        table_q.push_back(mkv("branch_n2",        1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0));
        table_q.push_back(mkv("trap_over_branch", 1, 0, 0, 1, 0, 1, 0, 0, 32'h200, 1, c_trap_t, 3, 1, 0, 0, 0, 0));
        table_q.push_back(mkv("reload_branch",    1, 0, 0, 0, 0, 1, 0, 0, 32'h204, 1, 32'h204, 2, 1, 1, 0, 1, 0));
        table_q.push_back(mkv("reload_n2",        1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 1, 1, 0, 1, 0));
        table_q.push_back(mkv("reload_n3",        1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0));
        table_q.push_back(mkv("pred_n",           1, 0, 0, 0, 0, 0, 1, 0, 32'h0,   c_pe, c_pe ? c_pred_t : 32'h0, c_pe ? 2'd1 : 2'd0, 0, 0, 0, 0, 0));
        table_q.push_back(mkv("pred_rejected",    1, 0, 0, 0, 0, 0, 1, 0, 32'h0,   0, 0, 0, 0, 0, c_pe, c_pe, 0));
        table_q.push_back(mkv("pred_again",       1, 0, 0, 0, 0, 0, 1, 0, 32'h0,   c_pe, c_pe ? c_pred_t : 32'h0, c_pe ? 2'd1 : 2'd0, 0, 0, 0, 0, 0));
        table_q.push_back(mkv("pred_holdoff",     1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 0, c_pe, c_pe, 0));
        table_q.push_back(mkv("stall_br_n",       1, 0, 0, 0, 0, 1, 0, 0, 32'h300, 1, 32'h300, 2, 1, 0, 0, 0, 0));
        table_q.push_back(mkv("stall_n1",         1, 0, 1, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 1, 1, 0, 1, 0));
        table_q.push_back(mkv("stall_n2",         1, 0, 1, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 1, 0, 0, 0, 1));
        table_q.push_back(mkv("stall_n3",         1, 0, 1, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 1, 0, 0, 0, 1));
        table_q.push_back(mkv("stall_n4",         1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 1, 0, 0, 0, 1));
        table_q.push_back(mkv("stall_n5",         1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0));
        table_q.push_back(mkv("branch_stalled",   1, 0, 1, 0, 0, 1, 0, 0, 32'h400, 0, 0, 0, 0, 0, 0, 0, 0));
        table_q.push_back(mkv("mret_stalled",     1, 0, 1, 0, 1, 0, 0, 0, 32'h0,   1, c_mret_t, 3, 1, 0, 0, 0, 1));
        table_q.push_back(mkv("mret_n1",          1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 1, 1, 0, 1, 1));
        table_q.push_back(mkv("hw_blocks_pred",   1, 0, 0, 0, 0, 0, 1, 1, 32'h0,   0, 0, 0, 0, 0, 0, 1, 0));
        table_q.push_back(mkv("stall_blocks_pred",1, 0, 1, 0, 0, 0, 1, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0));
        table_q.push_back(mkv("pre_reset_branch", 1, 0, 0, 0, 0, 1, 0, 0, 32'h600, 1, 32'h600, 2, 1, 0, 0, 0, 1));
        table_q.push_back(mkv("reset_mid_flush",  1, 1, 0, 1, 0, 0, 0, 0, 32'h0,   1, c_trap_t, 3, 1, 1, 0, 1, 0));
        table_q.push_back(mkv("after_reset",      1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0));

        foreach (table_q[i]) apply(table_q[i]);

        // Random-length stall after a branch: flush must hold through the first free cycle.
        for (int r = 0; r < 4; r++) begin
            k = $urandom_range(1, 5);
            apply(mkv("rnd_br", 1, 0, 0, 0, 0, 1, 0, 0, 32'h700 + r, 1, 32'h700 + r, 2, 1, 0, 0, 0, 0));
            for (int j = 0; j < k; j++)
                apply(mkv("rnd_stall", 1, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1,
                          (j == 0), 0, (j == 0), (j != 0)));
            apply(mkv("rnd_release", 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 0, 0, 0, 1));
            apply(mkv("rnd_idle",    1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
`default_nettype wire
